// File: rtl/input_pkg.sv
// Shared definitions for the button-to-command arbiter: button indices,
// FSM state encodings and a small elaboration-time helper.
package input_pkg;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_ROTATE = 2;
    localparam int BTN_SOFT   = 3;
    localparam int BTN_HARD   = 4;

    typedef enum logic {
        IDLE,
        OFFER
    } arb_state_t;

    typedef enum logic [1:0] {
        RELEASED,
        HOLD,
        REPEAT
    } rep_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_cmd_arbiter_if.sv
// Button inputs and command handshake between the debouncer bank, the
// arbiter (slave) and whatever drives/consumes it (master).
interface input_cmd_arbiter_if #(
    parameter int N_BTN = 5
);
    localparam int CODE_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    logic [N_BTN-1:0]  btn_level;
    logic [N_BTN-1:0]  btn_press;
    logic              cmd_ready;
    logic              cmd_valid;
    logic [CODE_W-1:0] cmd_code;
    logic [N_BTN-1:0]  pending;
    logic [7:0]        drop_count;

    modport master (
        output btn_level, btn_press, cmd_ready,
        input  cmd_valid, cmd_code, pending, drop_count
    );

    modport slave (
        input  btn_level, btn_press, cmd_ready,
        output cmd_valid, cmd_code, pending, drop_count
    );

endinterface

// File: rtl/input_repeat_timer.sv
// Per-button auto-repeat: after a press is held REPEAT_DELAY ticks, emits a
// repeat event, then one every REPEAT_PERIOD ticks until the button is released.
module input_repeat_timer
    import input_pkg::*;
#(
    parameter int REPEAT_DELAY  = 40,
    parameter int REPEAT_PERIOD = 10,
    parameter bit ENABLE        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic level,
    input  logic press,
    output logic repeat_evt
);

    localparam int CNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    rep_state_t       state, state_next;
    logic [CNT_W-1:0] tick_cnt, tick_cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RELEASED;
            tick_cnt <= '0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick_cnt_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        state_next    = state;
        tick_cnt_next = tick_cnt;
        repeat_evt    = 1'b0;
        if (!ENABLE || !level) begin
            state_next = RELEASED;
        end else if (press) begin
            state_next    = HOLD;
            tick_cnt_next = '0;
        end else if (tick_en) begin
            case (state)
                HOLD: begin
                    if (tick_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        repeat_evt    = 1'b1;
                        state_next    = REPEAT;
                        tick_cnt_next = '0;
                    end else begin
                        tick_cnt_next = tick_cnt + CNT_W'(1);
                    end
                end
                REPEAT: begin
                    if (tick_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                        repeat_evt    = 1'b1;
                        tick_cnt_next = '0;
                    end else begin
                        tick_cnt_next = tick_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/input_cmd_arbiter.sv
// Merges debounced button presses and auto-repeats into one command stream,
// granted round-robin over a valid/ready handshake (one command per 2 cycles max).
module input_cmd_arbiter
    import input_pkg::*;
#(
    parameter int               N_BTN         = 5,
    parameter int               TICK_DIV      = 125000,
    parameter int               REPEAT_DELAY  = 40,
    parameter int               REPEAT_PERIOD = 10,
    parameter logic [N_BTN-1:0] REPEAT_MASK   = 5'b01011
) (
    input  logic                 clk,
    input  logic                 rst,
    input_cmd_arbiter_if.slave   bus
);

    localparam int CODE_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick_en;
    logic [N_BTN-1:0]  repeat_evt;
    logic [N_BTN-1:0]  set_vec, clr_vec, drop_vec;
    logic [N_BTN-1:0]  pending_q, pending_next;
    logic [7:0]        drop_q, drop_next;
    int                drop_sum;
    logic              handshake;
    arb_state_t        state, state_next;
    logic [CODE_W-1:0] code_q, code_next, rr_q, rr_next;

    // First requesting index at or after ptr, wrapping past N_BTN-1.
    function automatic logic [CODE_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                  input logic [CODE_W-1:0] ptr);
        logic [CODE_W-1:0] best;
        int                best_d, d;
        best   = '0;
        best_d = N_BTN;
        for (int j = 0; j < N_BTN; j++) begin
            d = (j - int'(ptr) + N_BTN) % N_BTN;
            if (req[j] && d < best_d) begin
                best_d = d;
                best   = CODE_W'(j);
            end
        end
        return best;
    endfunction

    assign tick_en = (div_cnt == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          div_cnt <= '0;
        else if (tick_en) div_cnt <= '0;
        else              div_cnt <= div_cnt + DIV_W'(1);
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_timer
        input_repeat_timer #(
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .ENABLE        (REPEAT_MASK[i])
        ) u_timer (
            .clk        (clk),
            .rst        (rst),
            .tick_en    (tick_en),
            .level      (bus.btn_level[i]),
            .press      (bus.btn_press[i]),
            .repeat_evt (repeat_evt[i])
        );
    end

    assign handshake = (state == OFFER) && bus.cmd_ready;

    // A new set on the index being granted keeps it pending and is not a drop.
    always_comb begin
        set_vec = bus.btn_press | repeat_evt;
        clr_vec = '0;
        for (int j = 0; j < N_BTN; j++)
            clr_vec[j] = handshake && (code_q == CODE_W'(j));
        drop_vec     = set_vec & pending_q & ~clr_vec;
        pending_next = (pending_q & ~clr_vec) | set_vec;
        drop_sum     = int'(drop_q) + $countones(drop_vec);
        drop_next    = (drop_sum > 255) ? 8'd255 : 8'(drop_sum);
    end

    always_comb begin
        state_next = state;
        code_next  = code_q;
        rr_next    = rr_q;
        case (state)
            IDLE: begin
                if (|pending_q) begin
                    code_next  = rr_pick(pending_q, rr_q);
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (bus.cmd_ready) begin
                    rr_next    = (code_q == CODE_W'(N_BTN - 1)) ? '0 : code_q + CODE_W'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            code_q    <= '0;
            rr_q      <= '0;
            pending_q <= '0;
            drop_q    <= '0;
        end else begin
            state     <= state_next;
            code_q    <= code_next;
            rr_q      <= rr_next;
            pending_q <= pending_next;
            drop_q    <= drop_next;
        end
    end

    assign bus.cmd_valid  = (state == OFFER);
    assign bus.cmd_code   = code_q;
    assign bus.pending    = pending_q;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_input_cmd_arbiter.sv
// Self-checking bench: directed scenarios plus random button activity, compared
// every cycle against a tick/queue-level behavioural model of the arbiter.
module tb_input_cmd_arbiter;
    import input_pkg::*;

    localparam int N  = 5;
    localparam int TD = 4;
    localparam int RD = 3;
    localparam int RP = 2;
    localparam logic [N-1:0] MASK = 5'b01011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    input_cmd_arbiter_if #(.N_BTN(N)) bus ();

    input_cmd_arbiter #(
        .N_BTN         (N),
        .TICK_DIV      (TD),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .REPEAT_MASK   (MASK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cyc;
    bit m_hold[N];
    int m_ticks[N];
    bit m_pend[N];
    bit m_valid;
    int m_code, m_rr, m_drop;
    logic [N-1:0] mask_v = MASK;

    task automatic model_reset();
        m_cyc = 0; m_valid = 0; m_code = 0; m_rr = 0; m_drop = 0;
        for (int i = 0; i < N; i++) begin
            m_hold[i] = 0; m_ticks[i] = 0; m_pend[i] = 0;
        end
    endtask

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Advances the model across one clock edge given that cycle's inputs.
    task automatic model_step(input logic [N-1:0] lvl, input logic [N-1:0] prs, input logic rdy);
        bit tick, hs;
        bit setv[N];
        int pick;
        tick = (m_cyc % TD) == TD - 1;
        for (int i = 0; i < N; i++) begin
            setv[i] = prs[i];
            if (!lvl[i]) m_hold[i] = 0;
            else if (prs[i]) begin
                m_hold[i] = mask_v[i]; m_ticks[i] = 0;
            end else if (m_hold[i] && tick) begin
                m_ticks[i]++;
                if (m_ticks[i] == RD || (m_ticks[i] > RD && (m_ticks[i] - RD) % RP == 0))
                    setv[i] = 1;
            end
        end
        hs = m_valid && rdy;
        for (int i = 0; i < N; i++)
            if (setv[i] && m_pend[i] && !(hs && m_code == i))
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        pick = -1;
        for (int k = N - 1; k >= 0; k--)
            if (m_pend[(m_rr + k) % N]) pick = (m_rr + k) % N;
        if (hs) m_pend[m_code] = 0;
        for (int i = 0; i < N; i++) if (setv[i]) m_pend[i] = 1;
        if (hs) begin
            m_valid = 0; m_rr = (m_code + 1) % N;
        end else if (!m_valid && pick >= 0) begin
            m_valid = 1; m_code = pick;
        end
        m_cyc++;
    endtask

    // ---------------- compare + handshake log ----------------
    int cyc = 0;
    int hs_code[$];
    int hs_cyc[$];

    always @(posedge clk) begin
        if (!rst && bus.cmd_valid && bus.cmd_ready) begin
            hs_code.push_back(int'(bus.cmd_code));
            hs_cyc.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        #1;
        check("cmd_valid", bus.cmd_valid, m_valid);
        if (m_valid) check("cmd_code", bus.cmd_code, m_code);
        check("pending", bus.pending, pend_vec());
        check("drop_count", bus.drop_count, m_drop);
    end

    // ---------------- stimulus helpers ----------------
    logic [N-1:0] lvl_r = '0;
    logic         rdy_r = 1'b1;

    task automatic tick_cycle(input logic [N-1:0] prs);
        @(negedge clk);
        bus.btn_level = lvl_r;
        bus.btn_press = prs;
        bus.cmd_ready = rdy_r;
        if (!rst) model_step(lvl_r, prs, rdy_r);
    endtask

    task automatic idle(input int n);
        repeat (n) tick_cycle('0);
    endtask

    task automatic press(input logic [N-1:0] b);
        lvl_r = lvl_r | b;
        tick_cycle(b);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst = 1'b1;
        lvl_r = '0;
        bus.btn_level = '0;
        bus.btn_press = '0;
        model_reset();
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.cmd_ready = rdy_r;
        model_step('0, '0, rdy_r);
        hs_code.delete();
        hs_cyc.delete();
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p, g, waited;
        logic [N-1:0] nl;
        rst = 1'b0;
        bus.btn_level = '0;
        bus.btn_press = '0;
        bus.cmd_ready = 1'b1;
        model_reset();
        #1 rst = 1'b1;
        #1;
        check("reset_valid", bus.cmd_valid, 1'b0);
        check("reset_code", bus.cmd_code, 0);
        check("reset_pending", bus.pending, 0);
        check("reset_drop", bus.drop_count, 0);
        release_reset();

        // Single press of btn 1, released after 2 clk.
        press(5'b00010);
        p = cyc;
        idle(1);
        lvl_r = '0;
        idle(12);
        check("t1_count", hs_code.size(), 1);
        if (hs_code.size() == 1) begin
            check("t1_code", hs_code[0], BTN_RIGHT);
            check("t1_latency", hs_cyc[0] - p, 2);
        end

        // Hold btn 0 for 40 clk.
        do_reset();
        press(5'b00001);
        idle(39);
        lvl_r = '0;
        idle(12);
        check("t2_count", hs_code.size(), 5);
        if (hs_code.size() == 5) begin
            g = hs_cyc[1] - hs_cyc[0];
            check("t2_first_gap_in_range", (g >= 8 && g <= 16), 1'b1);
            check("t2_period_gap", hs_cyc[2] - hs_cyc[1], 8);
            check("t2_code", hs_code[4], BTN_LEFT);
        end

        // Simultaneous presses and round-robin pointer.
        do_reset();
        press(5'b10101);
        idle(1);
        lvl_r = '0;
        idle(10);
        check("t3_count_a", hs_code.size(), 3);
        if (hs_code.size() == 3) begin
            check("t3_a0", hs_code[0], 0);
            check("t3_a1", hs_code[1], 2);
            check("t3_a2", hs_code[2], 4);
        end
        hs_code.delete();
        press(5'b00010);
        idle(1);
        lvl_r = '0;
        idle(6);
        press(5'b00101);
        idle(1);
        lvl_r = '0;
        idle(8);
        check("t3_count_b", hs_code.size(), 3);
        if (hs_code.size() == 3) begin
            check("t3_b0", hs_code[0], 1);
            check("t3_b1", hs_code[1], 2);
            check("t3_b2", hs_code[2], 0);
        end

        // Stalled consumer, btn 3 pressed three times.
        do_reset();
        rdy_r = 1'b0;
        repeat (3) begin
            press(5'b01000);
            idle(1);
            lvl_r = '0;
            idle(2);
        end
        idle(8);
        check("t4_no_cmd_while_stalled", hs_code.size(), 0);
        check("t4_valid_held", bus.cmd_valid, 1'b1);
        check("t4_code_held", bus.cmd_code, BTN_SOFT);
        check("t4_drop", bus.drop_count, 2);
        rdy_r = 1'b1;
        idle(6);
        check("t4_count", hs_code.size(), 1);
        if (hs_code.size() == 1) check("t4_code", hs_code[0], BTN_SOFT);

        // Hard-drop has no auto-repeat.
        do_reset();
        press(5'b10000);
        idle(39);
        lvl_r = '0;
        idle(8);
        check("t5_count", hs_code.size(), 1);
        if (hs_code.size() == 1) check("t5_code", hs_code[0], BTN_HARD);
        check("t5_drop", bus.drop_count, 0);

        // Reset while a command is on offer.
        do_reset();
        rdy_r = 1'b0;
        press(5'b00100);
        idle(1);
        lvl_r = '0;
        waited = 0;
        while (!bus.cmd_valid && waited < 10) begin
            idle(1);
            waited++;
        end
        check("t6_offer_seen", bus.cmd_valid, 1'b1);
        assert_reset();
        #1;
        check("t6_valid_after_rst", bus.cmd_valid, 1'b0);
        check("t6_pending_after_rst", bus.pending, 0);
        rdy_r = 1'b1;
        release_reset();
        idle(10);
        check("t6_no_cmd", hs_code.size(), 0);

        // Random button activity with a random consumer.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) do_reset();
            nl = lvl_r;
            for (int i = 0; i < N; i++) begin
                if (lvl_r[i] && $urandom_range(0, 23) == 0) nl[i] = 1'b0;
                else if (!lvl_r[i] && $urandom_range(0, 15) == 0) nl[i] = 1'b1;
            end
            rdy_r = ($urandom_range(0, 3) != 0);
            lvl_r = nl;
            tick_cycle(nl & ~bus.btn_level);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
